// File: rtl/rename_pkg.sv
// Shared rename-stage definitions used by the tag free list and the map table.
// Contents: tag/pointer/count widths and types, and a 2-bit popcount helper.
// No ports; no optional feature in this file.
package rename_pkg;

  localparam int unsigned TAG_W    = 8;
  localparam int unsigned NUM_ARCH = 32;
  localparam int unsigned NUM_TAGS = 64;
  localparam int unsigned FL_DEPTH = NUM_TAGS - NUM_ARCH;
  localparam int unsigned FL_PTR_W = $clog2(FL_DEPTH);
  localparam int unsigned FL_CNT_W = FL_PTR_W + 1;

  typedef logic [TAG_W-1:0]    tag_t;
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;
  typedef logic [FL_CNT_W-1:0] fl_cnt_t;
  // One spare bit so overflow sums cannot wrap.
  typedef logic [FL_CNT_W:0]   fl_wcnt_t;

  function automatic logic [1:0] popcnt2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/tag_free_list_if.sv
// Dispatch/retire interface of the physical-tag free list.
// Signals:
//   alloc_req[1:0]  dispatch slot requests (bit0 slot 1, bit1 slot 2)
//   alloc_gnt       all requested tags granted (combinational)
//   alloc_tag1/2    show-ahead tags at head / head+1
//   free_valid[1:0], free_tag1/2  retirement frees pushed at tail
//   commit_cnt[1:0] allocated tags made architectural this cycle
//   flush           mispredict recovery
//   free_count      registered speculative free count
//   fl_error        sticky error flag (only with FREELIST_CHECK_EN)
// master = rename/retire side, slave = free list.
interface tag_free_list_if;
  import rename_pkg::*;

  logic [1:0] alloc_req;
  logic       alloc_gnt;
  tag_t       alloc_tag1;
  tag_t       alloc_tag2;
  logic [1:0] free_valid;
  tag_t       free_tag1;
  tag_t       free_tag2;
  logic [1:0] commit_cnt;
  logic       flush;
  fl_cnt_t    free_count;
  logic       fl_error;

  modport master (
    output alloc_req, free_valid, free_tag1, free_tag2, commit_cnt, flush,
    input  alloc_gnt, alloc_tag1, alloc_tag2, free_count, fl_error
  );

  modport slave (
    input  alloc_req, free_valid, free_tag1, free_tag2, commit_cnt, flush,
    output alloc_gnt, alloc_tag1, alloc_tag2, free_count, fl_error
  );

endinterface

// File: rtl/tag_fl_storage.sv
// Free-list entry storage: 2 write ports, 2 asynchronous read ports.
// Reset loads entry i with tag NUM_ARCH+i (all non-architectural tags free).
// Ports:
//   clock, reset            clock and synchronous active-high reset
//   we1_i/waddr1_i/wdata1_i write port 1
//   we2_i/waddr2_i/wdata2_i write port 2 (never same address as port 1)
//   raddr1_i/rdata1_o       read port 1
//   raddr2_i/rdata2_o       read port 2
module tag_fl_storage
  import rename_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    we1_i,
  input  fl_ptr_t waddr1_i,
  input  tag_t    wdata1_i,
  input  logic    we2_i,
  input  fl_ptr_t waddr2_i,
  input  tag_t    wdata2_i,
  input  fl_ptr_t raddr1_i,
  input  fl_ptr_t raddr2_i,
  output tag_t    rdata1_o,
  output tag_t    rdata2_o
);

  tag_t mem_q [FL_DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < FL_DEPTH; i++) begin
        mem_q[i] <= tag_t'(NUM_ARCH + i);
      end
    end else begin
      if (we1_i) mem_q[waddr1_i] <= wdata1_i;
      if (we2_i) mem_q[waddr2_i] <= wdata2_i;
    end
  end

  assign rdata1_o = mem_q[raddr1_i];
  assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/tag_free_list.sv
// Physical-tag free list: circular buffer of free tags with a speculative
// head (dispatch allocation), a committed head (retirement) and a tail
// (frees). Flush snaps the speculative head back to the committed head.
// Ports:
//   clock  single clock, posedge
//   reset  synchronous active-high reset
//   fl     tag_free_list_if.slave (alloc/free/commit/flush/status)
// Optional feature: define FREELIST_CHECK_EN to build the sticky fl_error
// checker (overflow, over-commit, illegal slot-2-only request); overflowing
// pushes are then dropped. Undefined: fl_error is tied low.
module tag_free_list
  import rename_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  tag_free_list_if.slave        fl
);

  fl_ptr_t head_q, head_d;
  fl_ptr_t chead_q, chead_d;
  fl_ptr_t tail_q, tail_d;
  fl_cnt_t spec_q, spec_d;
  fl_cnt_t cmt_q, cmt_d;

  logic [1:0] nreq;
  logic [1:0] nfree;
  logic [1:0] nfree_eff;
  logic       gnt;
  logic       push_ok;

  assign nreq  = popcnt2(fl.alloc_req);
  assign nfree = popcnt2(fl.free_valid);

  // Grant uses the registered count only; same-cycle frees are not bypassed.
  assign gnt = (nreq != 2'd0) && !fl.flush && (spec_q >= fl_cnt_t'(nreq));

`ifdef FREELIST_CHECK_EN
  logic overflow;
  logic bad_commit;
  logic bad_req;
  logic err_q;

  // cmt + freed > DEPTH + commit_cnt, rearranged so nothing can underflow.
  assign overflow   = (fl_wcnt_t'(cmt_q) + fl_wcnt_t'(nfree)) >
                      (fl_wcnt_t'(FL_DEPTH) + fl_wcnt_t'(fl.commit_cnt));
  // Allocated-but-uncommitted tags = committed free count - speculative count.
  assign bad_commit = fl_cnt_t'(fl.commit_cnt) > (cmt_q - spec_q);
  assign bad_req    = (fl.alloc_req == 2'b10);
  assign push_ok    = !overflow;

  always_ff @(posedge clock) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_q | overflow | bad_commit | bad_req;
  end

  assign fl.fl_error = err_q;
`else
  assign push_ok     = 1'b1;
  assign fl.fl_error = 1'b0;
`endif

  assign nfree_eff = push_ok ? nfree : 2'd0;

  always_comb begin
    head_d  = head_q + (gnt ? fl_ptr_t'(nreq) : '0);
    chead_d = chead_q + fl_ptr_t'(fl.commit_cnt);
    tail_d  = tail_q + fl_ptr_t'(nfree_eff);
    cmt_d   = cmt_q - fl_cnt_t'(fl.commit_cnt) + fl_cnt_t'(nfree_eff);
    spec_d  = spec_q - (gnt ? fl_cnt_t'(nreq) : '0) + fl_cnt_t'(nfree_eff);
    // Frees and commits of the flush cycle land first, then head snaps back.
    if (fl.flush) begin
      head_d = chead_d;
      spec_d = cmt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      chead_q <= '0;
      tail_q  <= '0;
      spec_q  <= fl_cnt_t'(FL_DEPTH);
      cmt_q   <= fl_cnt_t'(FL_DEPTH);
    end else begin
      head_q  <= head_d;
      chead_q <= chead_d;
      tail_q  <= tail_d;
      spec_q  <= spec_d;
      cmt_q   <= cmt_d;
    end
  end

  // A lone slot-2 free is compacted onto write port 1 at tail.
  tag_fl_storage u_storage (
    .clock    (clock),
    .reset    (reset),
    .we1_i    (push_ok && (fl.free_valid != 2'b00)),
    .waddr1_i (tail_q),
    .wdata1_i (fl.free_valid[0] ? fl.free_tag1 : fl.free_tag2),
    .we2_i    (push_ok && (fl.free_valid == 2'b11)),
    .waddr2_i (tail_q + fl_ptr_t'(1)),
    .wdata2_i (fl.free_tag2),
    .raddr1_i (head_q),
    .raddr2_i (head_q + fl_ptr_t'(1)),
    .rdata1_o (fl.alloc_tag1),
    .rdata2_o (fl.alloc_tag2)
  );

  assign fl.alloc_gnt  = gnt;
  assign fl.free_count = spec_q;

endmodule
